// File: rtl/systolic_pkg.sv
// Shared constants and FSM state encoding for the systolic array sequencer.
package systolic_pkg;

    localparam int unsigned DefSize    = 8;
    localparam int unsigned DefWidth   = 4;
    localparam int unsigned DefLatency = 9;

    localparam int unsigned InLaneW  = DefWidth;
    localparam int unsigned ResLaneW = DefWidth * DefWidth;

    typedef logic [2:0] state_t;

    localparam state_t StIdle   = 3'd0;
    localparam state_t StClear  = 3'd1;
    localparam state_t StLoadW  = 3'd2;
    localparam state_t StStream = 3'd3;
    localparam state_t StFlush  = 3'd4;
    localparam state_t StDrain  = 3'd5;

endpackage

// File: rtl/skew_line.sv
// Per-lane delay triangle: lane i delayed i cycles, or LANES-1-i when REVERSE is set.
module skew_line #(
    parameter int unsigned LANES   = 8,
    parameter int unsigned LANE_W  = 4,
    parameter bit          REVERSE = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [LANES*LANE_W-1:0] din,
    output logic [LANES*LANE_W-1:0] dout
);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        localparam int Depth = REVERSE ? int'(LANES) - 1 - i : i;

        if (Depth == 0) begin : g_wire
            assign dout[i*LANE_W +: LANE_W] = din[i*LANE_W +: LANE_W];
        end else begin : g_delay
            logic [LANE_W-1:0] stage_q [Depth];

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int k = 0; k < Depth; k++) stage_q[k] <= '0;
                end else begin
                    stage_q[0] <= din[i*LANE_W +: LANE_W];
                    for (int k = 1; k < Depth; k++) stage_q[k] <= stage_q[k-1];
                end
            end

            assign dout[i*LANE_W +: LANE_W] = stage_q[Depth-1];
        end
    end

endmodule

// File: rtl/systolic_sequencer.sv
// Sequences a weight-stationary systolic array: clear, load weight rows, stream skewed
// activations, capture de-skewed results into a buffer and return them over valid/ready.
module systolic_sequencer
    import systolic_pkg::*;
#(
    parameter int unsigned SIZE    = DefSize,
    parameter int unsigned WIDTH   = DefWidth,
    parameter int unsigned LATENCY = DefLatency
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        start,
    output logic                        busy,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [SIZE*WIDTH-1:0]       in_data,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [SIZE*WIDTH*WIDTH-1:0] res_data,
    output logic                        res_last,
    output logic                        sa_reset,
    output logic                        sa_load,
    output logic [SIZE*WIDTH-1:0]       sa_weights,
    output logic [SIZE*WIDTH-1:0]       sa_activations,
    input  logic [SIZE*WIDTH*WIDTH-1:0] sa_output
);

    localparam int unsigned InW    = SIZE * WIDTH;
    localparam int unsigned ResW   = SIZE * WIDTH * WIDTH;
    localparam int unsigned CntW   = $clog2(SIZE + 1);
    localparam int unsigned IdxW   = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int unsigned TagLen = LATENCY + SIZE;

    localparam logic [CntW-1:0] SizeC = CntW'(SIZE);
    localparam logic [CntW-1:0] LastC = CntW'(SIZE - 1);

    state_t            state_q, state_d;
    logic [CntW-1:0]   in_cnt_q, in_cnt_d;
    logic [CntW-1:0]   wr_cnt_q, wr_cnt_d;
    logic [CntW-1:0]   rd_cnt_q, rd_cnt_d;
    logic [TagLen-1:0] tag_q;
    logic              sa_reset_q, sa_load_q;
    logic [InW-1:0]    sa_weights_q, sa_act_q;
    logic [ResW-1:0]   res_buf_q [SIZE];

    logic           in_hs, res_hs, tag_in, capture;
    logic [InW-1:0] entered, skewed;
    logic [ResW-1:0] aligned;

    assign busy      = (state_q != StIdle);
    assign in_ready  = (state_q == StLoadW) || ((state_q == StStream) && (in_cnt_q < SizeC));
    assign res_valid = (state_q == StDrain);
    assign res_last  = res_valid && (rd_cnt_q == LastC);
    assign res_data  = res_valid ? res_buf_q[rd_cnt_q[IdxW-1:0]] : '0;

    assign sa_reset       = sa_reset_q;
    assign sa_load        = sa_load_q;
    assign sa_weights     = sa_weights_q;
    assign sa_activations = sa_act_q;

    assign in_hs   = in_valid && in_ready;
    assign res_hs  = res_valid && res_ready;
    assign tag_in  = (state_q == StStream) && in_hs;
    // Unaccepted cycles still push an all-zero bubble so lane timing stays fixed.
    assign entered = tag_in ? in_data : '0;
    assign capture = tag_q[TagLen-1] && (wr_cnt_q < SizeC);

    skew_line #(
        .LANES   (SIZE),
        .LANE_W  (WIDTH),
        .REVERSE (1'b0)
    ) u_in_skew (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (entered),
        .dout    (skewed)
    );

    skew_line #(
        .LANES   (SIZE),
        .LANE_W  (WIDTH * WIDTH),
        .REVERSE (1'b1)
    ) u_out_deskew (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (sa_output),
        .dout    (aligned)
    );

    always_comb begin
        state_d  = state_q;
        in_cnt_d = in_cnt_q;
        wr_cnt_d = capture ? wr_cnt_q + 1'b1 : wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d  = StClear;
                    in_cnt_d = '0;
                    wr_cnt_d = '0;
                    rd_cnt_d = '0;
                end
            end
            StClear: state_d = StLoadW;
            StLoadW: begin
                if (in_hs) begin
                    if (in_cnt_q == LastC) begin
                        in_cnt_d = '0;
                        state_d  = StStream;
                    end else begin
                        in_cnt_d = in_cnt_q + 1'b1;
                    end
                end
            end
            StStream: begin
                if (in_hs) begin
                    in_cnt_d = in_cnt_q + 1'b1;
                    if (in_cnt_q == LastC) state_d = StFlush;
                end
            end
            StFlush: begin
                if (capture && (wr_cnt_q == LastC)) state_d = StDrain;
            end
            StDrain: begin
                if (res_hs) begin
                    if (rd_cnt_q < SizeC) rd_cnt_d = rd_cnt_q + 1'b1;
                    if (rd_cnt_q == LastC) state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            in_cnt_q     <= '0;
            wr_cnt_q     <= '0;
            rd_cnt_q     <= '0;
            tag_q        <= '0;
            sa_reset_q   <= 1'b0;
            sa_load_q    <= 1'b0;
            sa_weights_q <= '0;
            sa_act_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_cnt_q   <= in_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            tag_q      <= {tag_q[TagLen-2:0], tag_in};
            sa_reset_q <= (state_q == StIdle) && start;
            sa_load_q  <= (state_q == StLoadW) && in_hs;
            if ((state_q == StLoadW) && in_hs) sa_weights_q <= in_data;
            sa_act_q   <= skewed;
        end
    end

    // Buffer contents are don't-care after reset; res_data is gated by res_valid.
    always_ff @(posedge clk) begin
        if (capture) res_buf_q[wr_cnt_q[IdxW-1:0]] <= aligned;
    end

endmodule

// File: tb/tb_systolic_sequencer.sv
// Directed bench for systolic_sequencer with a behavioural weight-stationary array model.
module tb_systolic_sequencer;

    localparam int SZ  = 8;
    localparam int LAT = 9;
    localparam int HD  = 4096;

    typedef struct {
        logic [31:0]  act;
        logic [127:0] exp;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic         busy;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         res_valid;
    logic         res_ready;
    logic [127:0] res_data;
    logic         res_last;
    logic         sa_reset;
    logic         sa_load;
    logic [31:0]  sa_weights;
    logic [31:0]  sa_activations;
    logic [127:0] sa_output = '0;

    int ntests = 0;
    int nfail  = 0;
    int cyc    = 0;
    int load_cnt = 0;
    int rst_cnt  = 0;
    int g_acc, g_lastw, g_v0, g_v7, g_first_valid;

    vec_t         tbl [24];
    logic [31:0]  hist [HD];
    logic [31:0]  wmem [SZ];
    int           lptr = 0;
    logic [127:0] model_out;

    systolic_sequencer #(
        .SIZE    (SZ),
        .WIDTH   (4),
        .LATENCY (LAT)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .busy           (busy),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_data       (res_data),
        .res_last       (res_last),
        .sa_reset       (sa_reset),
        .sa_load        (sa_load),
        .sa_weights     (sa_weights),
        .sa_activations (sa_activations),
        .sa_output      (sa_output)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Array model: result lane j of the vector whose lane 0 appeared at cycle c0 shows up at
    // c0+LAT+j and is sum_i act[i]*W[i][j], with act[i] seen on sa_activations at c0+i.
    always_comb begin
        model_out = '0;
        for (int j = 0; j < SZ; j++) begin
            int sum;
            sum = 0;
            for (int i = 0; i < SZ; i++) begin
                int idx;
                idx = cyc - LAT - j + i;
                if (idx >= 0 && idx < HD)
                    sum += int'(hist[idx][4*i +: 4]) * int'(wmem[i][4*j +: 4]);
            end
            model_out[16*j +: 16] = 16'(sum);
        end
    end

    always @(negedge clk) begin
        if (cyc < HD) hist[cyc] <= sa_activations;
        sa_output <= model_out;
        if (sa_reset) begin
            for (int r = 0; r < SZ; r++) wmem[r] <= '0;
            lptr <= 0;
        end else if (sa_load && lptr < SZ) begin
            wmem[lptr] <= sa_weights;
            lptr <= lptr + 1;
        end
        if (sa_load) load_cnt <= load_cnt + 1;
        if (sa_reset) rst_cnt <= rst_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chkv(input string name, input logic [127:0] act, input logic [127:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_in_ready"}, in_ready, 1'b0);
        chk1({tag, "_res_valid"}, res_valid, 1'b0);
        chk1({tag, "_res_last"}, res_last, 1'b0);
        chk1({tag, "_sa_reset"}, sa_reset, 1'b0);
        chk1({tag, "_sa_load"}, sa_load, 1'b0);
        chkv({tag, "_sa_weights"}, 128'(sa_weights), '0);
        chkv({tag, "_sa_act"}, 128'(sa_activations), '0);
        chkv({tag, "_res_data"}, res_data, '0);
    endtask

    function automatic logic [31:0] wrow(input bit shift, input int r);
        int lane;
        lane = shift ? (r + 1) % SZ : r;
        return 32'h1 << (4 * lane);
    endfunction

    // Called at a negedge; returns at the negedge after the handshake.
    task automatic send(input logic [31:0] d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        ntests++;
        if (!in_ready) begin
            nfail++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", n);
        end
        g_acc = cyc;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic collect(input int base, input bit bp);
        int b;
        int guard;
        logic [127:0] held;
        logic         held_last;
        b = 0;
        guard = 0;
        g_first_valid = -1;
        while (b < SZ && guard < 100) begin
            if (res_valid) begin
                if (g_first_valid < 0) g_first_valid = cyc;
                if (bp && b == 3) begin
                    res_ready = 1'b0;
                    held = res_data;
                    held_last = res_last;
                    repeat (10) begin
                        @(negedge clk);
                        chk1("bp_valid", res_valid, 1'b1);
                        chkv("bp_data_stable", res_data, held);
                        chk1("bp_last_stable", res_last, held_last);
                    end
                    res_ready = 1'b1;
                end
                chkv($sformatf("res%0d_data", b), res_data, tbl[base+b].exp);
                chk1($sformatf("res%0d_last", b), res_last, b == SZ - 1);
                b++;
            end
            @(negedge clk);
            guard++;
        end
        ntests++;
        if (b < SZ) begin
            nfail++;
            $display("FAIL collect_timeout: got %0d beats required %0d", b, SZ);
        end
        chk1("post_res_valid", res_valid, 1'b0);
        chk1("post_busy", busy, 1'b0);
    endtask

    task automatic run_job(input int base, input bit shift, input bit bubbles, input bit bp,
                           input bit smid, input bit rmid, input bit timing);
        int loads0, rsts0;
        loads0 = load_cnt;
        rsts0  = rst_cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk1("clear_busy", busy, 1'b1);
        chk1("clear_in_ready", in_ready, 1'b0);
        chk1("clear_sa_reset", sa_reset, 1'b1);
        @(negedge clk);
        chk1("first_in_ready", in_ready, 1'b1);
        chk1("load_sa_reset", sa_reset, 1'b0);
        for (int r = 0; r < SZ; r++) send(wrow(shift, r));
        g_lastw = g_acc;
        for (int k = 0; k < SZ; k++) begin
            if (smid && k == 4) start = 1'b1;
            send(tbl[base+k].act);
            start = 1'b0;
            if (k == 0) g_v0 = g_acc;
            g_v7 = g_acc;
            if (rmid && k == 3) begin
                #2 reset_n = 1'b0;
                #1 chk_zero("midrst");
                @(negedge clk);
                @(negedge clk);
                reset_n = 1'b1;
                @(negedge clk);
                chk1("midrst_idle_busy", busy, 1'b0);
                return;
            end
            if (bubbles) @(negedge clk);
        end
        collect(base, bp);
        if (timing) begin
            chkv("w_to_act_gap", 128'(g_v0 - g_lastw), 128'(1));
            chkv("res_valid_latency", 128'(g_first_valid - g_v7), 128'(LAT + SZ + 1));
        end
        chkv("sa_load_pulses", 128'(load_cnt - loads0), 128'(SZ));
        chkv("sa_reset_cycles", 128'(rst_cnt - rsts0), 128'(1));
    endtask

    initial begin
        tbl[0]  = '{32'h11111111, 128'h0001_0001_0001_0001_0001_0001_0001_0001};
        tbl[1]  = '{32'h22222222, 128'h0002_0002_0002_0002_0002_0002_0002_0002};
        tbl[2]  = '{32'h33333333, 128'h0003_0003_0003_0003_0003_0003_0003_0003};
        tbl[3]  = '{32'h44444444, 128'h0004_0004_0004_0004_0004_0004_0004_0004};
        tbl[4]  = '{32'h55555555, 128'h0005_0005_0005_0005_0005_0005_0005_0005};
        tbl[5]  = '{32'h66666666, 128'h0006_0006_0006_0006_0006_0006_0006_0006};
        tbl[6]  = '{32'h77777777, 128'h0007_0007_0007_0007_0007_0007_0007_0007};
        tbl[7]  = '{32'h88888888, 128'h0008_0008_0008_0008_0008_0008_0008_0008};
        // Weights route input lane i to output lane (i+1)%8.
        tbl[8]  = '{32'h76543210, 128'h0006_0005_0004_0003_0002_0001_0000_0007};
        tbl[9]  = '{32'h87654321, 128'h0007_0006_0005_0004_0003_0002_0001_0008};
        tbl[10] = '{32'h98765432, 128'h0008_0007_0006_0005_0004_0003_0002_0009};
        tbl[11] = '{32'ha9876543, 128'h0009_0008_0007_0006_0005_0004_0003_000a};
        tbl[12] = '{32'hba987654, 128'h000a_0009_0008_0007_0006_0005_0004_000b};
        tbl[13] = '{32'hcba98765, 128'h000b_000a_0009_0008_0007_0006_0005_000c};
        tbl[14] = '{32'hdcba9876, 128'h000c_000b_000a_0009_0008_0007_0006_000d};
        tbl[15] = '{32'hedcba987, 128'h000d_000c_000b_000a_0009_0008_0007_000e};
        tbl[16] = '{32'hffffffff, 128'h000f_000f_000f_000f_000f_000f_000f_000f};
        for (int k = 17; k < 24; k++) tbl[k] = '{32'h0, 128'h0};

        reset_n = 1'b0;
        repeat (4) begin
            @(negedge clk);
            start     = 1'($urandom_range(0, 1));
            in_valid  = 1'($urandom_range(0, 1));
            res_ready = 1'($urandom_range(0, 1));
            in_data   = $urandom();
        end
        #1 chk_zero("rst");
        @(negedge clk);
        reset_n = 1'b1;
        start   = 1'b0;
        repeat (8) begin
            in_valid  = 1'($urandom_range(0, 1));
            res_ready = 1'($urandom_range(0, 1));
            in_data   = $urandom();
            @(negedge clk);
            chk1("nostart_busy", busy, 1'b0);
            chk1("nostart_in_ready", in_ready, 1'b0);
            chk1("nostart_sa_load", sa_load, 1'b0);
        end
        in_valid  = 1'b0;
        in_data   = '0;
        res_ready = 1'b1;
        @(negedge clk);

        run_job(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        run_job(16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < SZ; i++) begin
            chkv($sformatf("skew_pre_l%0d", i), 128'(hist[g_v0+i][4*i +: 4]), 128'(0));
            chkv($sformatf("skew_hit_l%0d", i), 128'(hist[g_v0+1+i][4*i +: 4]), 128'(15));
            chkv($sformatf("skew_post_l%0d", i), 128'(hist[g_v0+2+i][4*i +: 4]), 128'(0));
        end

        run_job(8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        run_job(0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        run_job(8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        chk1("ignored_start_busy", busy, 1'b0);

        run_job(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        run_job(8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
